// File: rtl/inv_sqrt_arbiter.sv
// rtl/inv_sqrt_arbiter.sv - round-robin arbiter sharing one pipelined inverse-square-root unit
// Optional per-requester completion counters are enabled by defining INV_SQRT_ARB_STATS_EN.
module inv_sqrt_arbiter #(
  parameter int N_REQ   = 4,
  parameter int I_DATA  = 32,
  parameter int LATENCY = 14,
  localparam int TAG_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*I_DATA-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [I_DATA-1:0]       rsp_data,
  input  logic                    drain,
  output logic                    idle,
  output logic                    drain_done,
  output logic                    sq_enable,
  output logic [I_DATA-1:0]       sq_idata,
  input  logic [I_DATA-1:0]       sq_odata,
  input  logic                    sq_out_valid,
  output logic                    err_unexpected
`ifdef INV_SQRT_ARB_STATS_EN
  ,
  input  logic [TAG_W-1:0]        stat_sel,
  output logic [31:0]             stat_count
`endif
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [TAG_W-1:0]  rr_ptr;
  logic [TAG_W-1:0]  grant_idx;
  logic              grant_any;
  logic [CNT_W-1:0]  inflight;
  logic              pipe_v   [LATENCY];
  logic [TAG_W-1:0]  pipe_tag [LATENCY];
  logic              out_v;
  logic [TAG_W-1:0]  out_tag;
  logic              rsp_hit;
  logic [I_DATA-1:0] req_word [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_word[g] = req_data[g*I_DATA +: I_DATA];
  end

  function automatic logic [TAG_W-1:0] wrap_idx(input logic [TAG_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return TAG_W'(s);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Grant search starts just past the last winner, so a held request cannot starve others.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    sq_enable = 1'b0;
    sq_idata  = '0;
    grant_idx = rr_ptr;
    grant_any = 1'b0;
    case (state)
      ST_RUN:   if (drain)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (!drain) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
    if (state == ST_RUN) begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (!grant_any && req_valid[wrap_idx(rr_ptr, k)]) begin
          grant_any = 1'b1;
          grant_idx = wrap_idx(rr_ptr, k);
        end
      end
      if (grant_any) begin
        req_ready[grant_idx] = 1'b1;
        sq_enable            = 1'b1;
        sq_idata             = req_word[grant_idx];
      end
    end
  end

  assign out_v      = pipe_v[LATENCY-1];
  assign out_tag    = pipe_tag[LATENCY-1];
  assign rsp_hit    = out_v & sq_out_valid;
  assign idle       = (inflight == '0);
  assign drain_done = (state == ST_DRAIN) && idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr         <= TAG_W'(N_REQ - 1);
      inflight       <= '0;
      rsp_valid      <= '0;
      rsp_data       <= '0;
      err_unexpected <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_tag[i] <= '0;
      end
    end else begin
      if (sq_enable) rr_ptr <= grant_idx;
      pipe_v[0]   <= sq_enable;
      pipe_tag[0] <= grant_idx;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      rsp_valid <= rsp_hit ? (N_REQ'(1) << out_tag) : '0;
      if (rsp_hit) rsp_data <= sq_odata;
      // A result without a tag, or a tag without a result, means the unit and pipe disagree.
      if (out_v ^ sq_out_valid) err_unexpected <= 1'b1;
      case ({sq_enable, out_v})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

`ifdef INV_SQRT_ARB_STATS_EN
  logic [31:0] stat_cnt [N_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) stat_cnt[i] <= '0;
      stat_count <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (rsp_hit && out_tag == TAG_W'(i) && stat_cnt[i] != 32'hFFFF_FFFF)
          stat_cnt[i] <= stat_cnt[i] + 32'd1;
      end
      stat_count <= (int'(stat_sel) < N_REQ) ? stat_cnt[stat_sel] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_inv_sqrt_arbiter.sv
// tb/tb_inv_sqrt_arbiter.sv - randomized scoreboard bench for inv_sqrt_arbiter
module tb_inv_sqrt_arbiter;

  localparam int N       = 4;
  localparam int D       = 32;
  localparam int L       = 14;
  localparam int RSP_LAT = L + 1;
  localparam logic [D-1:0] KEY = 32'hA5A5A5A5;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*D-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [D-1:0]   rsp_data;
  logic           drain;
  logic           idle;
  logic           drain_done;
  logic           sq_enable;
  logic [D-1:0]   sq_idata;
  logic [D-1:0]   sq_odata;
  logic           sq_out_valid;
  logic           err_unexpected;
`ifdef INV_SQRT_ARB_STATS_EN
  logic [1:0]     stat_sel;
  logic [31:0]    stat_count;
`endif

  inv_sqrt_arbiter #(.N_REQ(N), .I_DATA(D), .LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .drain(drain), .idle(idle), .drain_done(drain_done),
    .sq_enable(sq_enable), .sq_idata(sq_idata),
    .sq_odata(sq_odata), .sq_out_valid(sq_out_valid),
    .err_unexpected(err_unexpected)
`ifdef INV_SQRT_ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_count(stat_count)
`endif
  );

  // Unit model: fixed-latency delay line producing operand ^ KEY.
  logic         dl_v [L];
  logic [D-1:0] dl_d [L];
  logic         inject;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < L; i++) begin
        dl_v[i] <= 1'b0;
        dl_d[i] <= '0;
      end
    end else begin
      dl_v[0] <= sq_enable;
      dl_d[0] <= sq_idata ^ KEY;
      for (int i = 1; i < L; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_d[i] <= dl_d[i-1];
      end
    end
  end
  assign sq_out_valid = dl_v[L-1] | inject;
  assign sq_odata     = dl_d[L-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int           tag;
    logic [D-1:0] data;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  int           launch_q[$];
  int           grant_log[$];
  int           checks = 0;
  int           errors = 0;
  int           m_last;
  bit           m_drain;
  bit           m_err;
  bit           force_d0;
  int           peak;
  int           rsp_count = 0;
  logic [D-1:0] last_rsp_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_inflight();
    int n = 0;
    foreach (launch_q[i])
      if (launch_q[i] < cyc && launch_q[i] + RSP_LAT > cyc) n++;
    return n;
  endfunction

  // One cycle of stimulus, checked against the round-robin rules.
  task automatic drive(input logic [N-1:0] v, input bit dr);
    int           g;
    int           infl;
    logic [N-1:0] er;
    logic [D-1:0] ed;
    exp_t         e;
    @(negedge clk);
    req_valid = v;
    drain     = dr;
    for (int i = 0; i < N; i++) req_data[i*D +: D] = $urandom;
    if (force_d0) req_data[D-1:0] = 32'h3F800000;
    #1;
    g = -1;
    if (!m_drain)
      for (int k = 1; k <= N; k++)
        if (g < 0 && v[(m_last + k) % N]) g = (m_last + k) % N;
    er = '0;
    ed = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      ed    = req_data[g*D +: D];
    end
    infl = model_inflight();
    check("req_ready", req_ready, er);
    check("sq_enable", sq_enable, g >= 0);
    check("sq_idata", sq_idata, ed);
    check("inflight", dut.inflight, infl);
    check("idle", idle, infl == 0);
    check("drain_done", drain_done, m_drain && infl == 0);
    check("err_unexpected", err_unexpected, m_err);
    if (int'(dut.inflight) > peak) peak = int'(dut.inflight);
    if (g >= 0) begin
      e.tag  = g;
      e.data = ed ^ KEY;
      e.due  = cyc + RSP_LAT;
      exp_q.push_back(e);
      launch_q.push_back(cyc);
      grant_log.push_back(g);
      m_last = g;
    end
    m_drain = dr;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rsp_valid != '0) begin
          rsp_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: rsp_valid %b with nothing outstanding (cycle %0d)", rsp_valid, cyc);
          end else begin
            e = exp_q.pop_front();
            check("rsp_valid", rsp_valid, N'(1) << e.tag);
            check("rsp_data", rsp_data, e.data);
            check("rsp_cycle", cyc, e.due);
            last_rsp_data = rsp_data;
          end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL rsp_missing: got no rsp_valid at cycle %0d expected tag %0d due %0d", cyc, exp_q[0].tag, exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 0);
    check("rst_sq_enable", sq_enable, 0);
    check("rst_sq_idata", sq_idata, 0);
    check("rst_idle", idle, 1);
    check("rst_drain_done", drain_done, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_err", err_unexpected, 0);
  endtask

  initial begin : stim
    int n0;
    int r0;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    drain     = 1'b0;
    inject    = 1'b0;
    force_d0  = 1'b0;
    m_last    = N - 1;
    m_drain   = 1'b0;
    m_err     = 1'b0;
    peak      = 0;
`ifdef INV_SQRT_ARB_STATS_EN
    stat_sel  = '0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    force_d0 = 1'b1;
    drive(4'b0001, 1'b0);
    force_d0 = 1'b0;
    repeat (16) drive('0, 1'b0);
    check("single_rsp_data", last_rsp_data, 32'h9A25A5A5);

    drive(4'b1000, 1'b0);
    repeat (16) drive('0, 1'b0);

    grant_log.delete();
    peak = 0;
    repeat (8) drive(4'hF, 1'b0);
    repeat (16) drive('0, 1'b0);
    check("all4_grant_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      check("all4_grant_order", grant_log[i], i % 4);
    check("all4_peak_inflight", peak, 8);

    peak = 0;
    r0   = rsp_count;
    repeat (20) drive(4'b0100, 1'b0);
    repeat (16) drive('0, 1'b0);
    check("b2b_peak_inflight", peak, 14);
    check("b2b_rsp_count", rsp_count - r0, 20);

    repeat (5) drive(4'hF, 1'b0);
    n0 = grant_log.size();
    repeat (21) drive(4'hF, 1'b1);
    check("drain_extra_grants", grant_log.size() - n0, 1);
    n0 = grant_log.size();
    repeat (3) drive(4'hF, 1'b0);
    check("drain_resume_grants", grant_log.size() - n0, 2);
    repeat (16) drive('0, 1'b0);

    repeat (200) drive(N'($urandom), $urandom_range(0, 9) == 0);
    repeat (17) drive('0, 1'b0);

    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    m_err  = 1'b1;
    drive('0, 1'b0);
    check("inject_no_rsp", rsp_valid, 0);
    repeat (3) drive('0, 1'b0);

    repeat (6) drive(4'hF, 1'b0);
    #2;
    reset     = 1'b1;
    req_valid = '0;
    #1;
    check_reset_outputs();
    check("rst_inflight", dut.inflight, 0);
    exp_q.delete();
    launch_q.delete();
    m_last  = N - 1;
    m_drain = 1'b0;
    m_err   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) drive('0, 1'b0);
    drive(4'b0001, 1'b0);
    repeat (16) drive('0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_sqrt_arbiter.md
Name: inv_sqrt_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one fully pipelined inverse-square-root unit between N_REQ requesters, e.g. the per-antenna column-norm normalisers in the MIMO detector.
- Accepts at most one operand per cycle and launches it into the unit.
- Tracks each in-flight operation's requester tag in a latency-matched shift pipe and routes each result back to the requester that issued it.
- Provides a drain mode so upstream control can quiesce the shared unit before reconfiguration.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- I_DATA, 32, operand/result width (IEEE-754 single by default).
- LATENCY, 14, cycles from sq_enable/sq_idata accepted to the matching sq_out_valid; must equal the attached unit's latency.
- TAG_W, $clog2(N_REQ), requester tag width (derived, not overridden).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  N_REQ  per-requester operand valid
- req_data  input  N_REQ*I_DATA  packed operands; requester i at [i*I_DATA +: I_DATA]
- req_ready  output  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- rsp_valid  output  N_REQ  one-hot result strobe, single cycle, no backpressure
- rsp_data  output  I_DATA  result, shared by all requesters
- drain  input  1  level; when high, stop granting new operations
- idle  output  1  high when no operation is in flight
- drain_done  output  1  high while drain=1 and the pipe is empty
- sq_enable  output  1  launch strobe to the inv_sqrt unit
- sq_idata  output  I_DATA  operand to the inv_sqrt unit
- sq_odata  input  I_DATA  result from the unit
- sq_out_valid  input  1  result valid from the unit
- err_unexpected  output  1  sticky; a result/tag mismatch has occurred

Behaviour:
- Reset (asynchronous, active-high) forces: rr_ptr=N_REQ-1, tag pipe cleared, inflight=0, state=RUN, rsp_valid=0, rsp_data=0, err_unexpected=0. With no requests pending, req_ready=0, sq_enable=0, sq_idata=0, idle=1, drain_done=0.
- States:
  - RUN: grants allowed.
  - DRAIN: no grants.
  - RUN->DRAIN when drain=1; DRAIN->RUN when drain=0. Both transitions are registered.
  - drain_done = (state==DRAIN) & (inflight==0).
- Grant is combinational in RUN:
  - Pick the first i with req_valid[i]=1, searching from rr_ptr+1 modulo N_REQ.
  - req_ready is one-hot at that i, zero otherwise, and zero in DRAIN.
  - On transfer: sq_enable=1, sq_idata=req_data[i], rr_ptr<=i.
  - If nothing is valid: sq_enable=0, sq_idata=0, rr_ptr holds.
- A requester may hold req_valid across cycles. After it wins, it cannot win again while any other requester is waiting.
- Tag pipe: LATENCY-deep shift register of {v, tag}, shifting every cycle.
  - Stage 0 loads {sq_enable, granted i}.
  - The pipe output is aligned with sq_out_valid.
- Response, registered one cycle after sq_out_valid:
  - rsp_valid[tag]<=1 and rsp_data<=sq_odata when pipe-out v=1 and sq_out_valid=1.
  - Otherwise rsp_valid<=0 and rsp_data holds.
- inflight:
  - +1 on launch, -1 when pipe-out v=1, unchanged when both happen in the same cycle.
  - Range is 0..LATENCY; it never exceeds LATENCY because at most one launch occurs per cycle.
  - idle = (inflight==0).
- Errors:
  - sq_out_valid=1 with pipe-out v=0 sets err_unexpected; no response is emitted.
  - pipe-out v=1 with sq_out_valid=0 sets err_unexpected; the entry is dropped.
  - err_unexpected clears only on reset.
- Throughput: one issue per cycle sustained. End-to-end latency from grant to rsp_valid is LATENCY+1 cycles.
- drain asserted in the same cycle as a pending request: that cycle's grant still occurs, because the state update is registered.
- Reset mid-operation: all in-flight tags are discarded. Any unit results arriving after reset set err_unexpected; upstream must also reset the unit.

Optional Feature:
- Macro: INV_SQRT_ARB_STATS_EN.
- Defined:
  - Adds input stat_sel (TAG_W) and output stat_count (32).
  - Per-requester 32-bit counters of completed responses, saturating at 0xFFFFFFFF, cleared by reset.
  - stat_count is the registered value of counter[stat_sel], with 1-cycle read latency.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- The bench uses a LATENCY=14 delay-line model of the unit, with sq_odata = operand XOR 0xA5A5A5A5.
- Single request: req_valid=0001, data 0x3F800000 -> req_ready=0001 in the same cycle; rsp_valid=0001 with rsp_data=0x9A25A5A5 exactly 15 cycles later; idle returns to 1.
- All four requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 responses in the same order with correct tags; inflight peaks at 8.
- Back-to-back issue for 20 cycles from requester 2 only -> 20 consecutive rsp_valid=0100; inflight saturates at 14 and sq_enable never drops.
- Drain: drain=1 while 5 operations are in flight and requests are pending -> at most one more grant, then req_ready=0; drain_done=1 exactly when the last response is emitted; deasserting drain resumes grants.
- Model injects a spurious sq_out_valid with an empty pipe -> err_unexpected=1 with no rsp_valid pulse; asserting reset mid-burst clears all outputs to their reset values immediately.
